// File: rtl/sine_lut_arbiter.sv
// Shares one quarter-wave sine ROM between the video and audio requesters.
// Each cycle grants at most one lookup, folds its phase onto the table, and returns a signed result two cycles after the grant.
module sine_lut_arbiter #(
    parameter int unsigned PHASE_BITS     = 10,
    parameter int unsigned TABLE_BITS     = 8,
    parameter int unsigned OUT_BITS       = 8,
    parameter int unsigned AUDIO_MAX_WAIT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  v_req,
    input  logic [PHASE_BITS-1:0] v_phase,
    output logic                  v_ack,
    output logic                  v_valid,
    output logic [OUT_BITS:0]     v_data,
    input  logic                  a_req,
    input  logic [PHASE_BITS-1:0] a_phase,
    output logic                  a_ack,
    output logic                  a_valid,
    output logic [OUT_BITS:0]     a_data,
    output logic [TABLE_BITS-1:0] rom_addr,
    input  logic [OUT_BITS-1:0]   rom_data
);

    localparam int unsigned CNT_BITS = $clog2(AUDIO_MAX_WAIT + 1);
    localparam int unsigned RES_BITS = OUT_BITS + 1;
    localparam logic [CNT_BITS-1:0] CNT_MAX = CNT_BITS'(AUDIO_MAX_WAIT);
    localparam logic OWNER_VIDEO = 1'b0;
    localparam logic OWNER_AUDIO = 1'b1;

    logic [CNT_BITS-1:0]   starve_q,   starve_d;
    logic [TABLE_BITS-1:0] rom_addr_q, rom_addr_d;
    logic                  sign_q,     sign_d;
    logic                  s1_valid_q, s1_valid_d;
    logic                  s1_owner_q, s1_owner_d;
    logic                  v_valid_q,  v_valid_d;
    logic                  a_valid_q,  a_valid_d;
    logic [RES_BITS-1:0]   v_data_q,   v_data_d;
    logic [RES_BITS-1:0]   a_data_q,   a_data_d;

    logic                  grant_v;
    logic                  grant_a;
    logic [PHASE_BITS-1:0] g_phase;
    logic [1:0]            quad;
    logic [RES_BITS-1:0]   mag;
    logic [RES_BITS-1:0]   result;

    // Video has priority unless audio is alone or has waited too long.
    always_comb begin
        grant_v = 1'b0;
        grant_a = 1'b0;
        if (!reset) begin
            if (a_req && (!v_req || (starve_q >= CNT_MAX))) begin
                grant_a = 1'b1;
            end else if (v_req) begin
                grant_v = 1'b1;
            end
        end
    end

    always_comb begin
        starve_d = starve_q;
        if (!a_req || grant_a) begin
            starve_d = '0;
        end else if (starve_q < CNT_MAX) begin
            starve_d = starve_q + CNT_BITS'(1);
        end
    end

    // Stage 1: fold the granted phase into a table address and a sign, and tag the owner.
    always_comb begin
        g_phase    = grant_a ? a_phase : v_phase;
        quad       = g_phase[PHASE_BITS-1:PHASE_BITS-2];
        rom_addr_d = rom_addr_q;
        sign_d     = sign_q;
        s1_owner_d = s1_owner_q;
        s1_valid_d = grant_v | grant_a;
        if (grant_v || grant_a) begin
            rom_addr_d = quad[0] ? ~g_phase[TABLE_BITS-1:0] : g_phase[TABLE_BITS-1:0];
            sign_d     = quad[1];
            s1_owner_d = grant_a ? OWNER_AUDIO : OWNER_VIDEO;
        end
    end

    // Stage 2: apply the sign to the table magnitude and write it to the owner's register.
    always_comb begin
        mag       = {1'b0, rom_data};
        result    = sign_q ? (RES_BITS'(0) - mag) : mag;
        v_valid_d = s1_valid_q && (s1_owner_q == OWNER_VIDEO);
        a_valid_d = s1_valid_q && (s1_owner_q == OWNER_AUDIO);
        v_data_d  = v_valid_d ? result : v_data_q;
        a_data_d  = a_valid_d ? result : a_data_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_q   <= '0;
            rom_addr_q <= '0;
            sign_q     <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_owner_q <= 1'b0;
            v_valid_q  <= 1'b0;
            a_valid_q  <= 1'b0;
            v_data_q   <= '0;
            a_data_q   <= '0;
        end else begin
            starve_q   <= starve_d;
            rom_addr_q <= rom_addr_d;
            sign_q     <= sign_d;
            s1_valid_q <= s1_valid_d;
            s1_owner_q <= s1_owner_d;
            v_valid_q  <= v_valid_d;
            a_valid_q  <= a_valid_d;
            v_data_q   <= v_data_d;
            a_data_q   <= a_data_d;
        end
    end

    assign v_ack    = grant_v;
    assign a_ack    = grant_a;
    assign v_valid  = v_valid_q;
    assign a_valid  = a_valid_q;
    assign v_data   = v_data_q;
    assign a_data   = a_data_q;
    assign rom_addr = rom_addr_q;

endmodule
